stage_exe_mc: RTL and testbench

Parametrised execute stage for the pipelined MIPS core. It generalises the single-cycle execute stage in three ways: configurable data width, valid/ready handshakes on both sides, and beq/bne branch modes. It also adds an iterative unsigned multiply/divide unit that takes WIDTH cycles and back-pressures the decode stage while it runs. It sits between the decode stage (operands, immediate, npc, control) and the memory stage (result, branch redirect).

---
 rtl/stage_exe_mc.sv | 209 ++++++++++++++++++++
 tb/tb_stage_exe_mc.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/stage_exe_mc.sv
// Execute stage for the pipelined MIPS core: single-cycle ALU with beq/bne redirect,
// plus an optional iterative unsigned multiply/divide unit, valid/ready on both sides.
module stage_exe_mc #(
  parameter int WIDTH     = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [WIDTH-1:0] data_imm,
  input  logic [WIDTH-1:0] npc,
  input  logic [2:0]       control_alu_op,
  input  logic             control_use_b,
  input  logic [1:0]       control_branch,
  input  logic [1:0]       control_muldiv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             use_npc,
  output logic [WIDTH-1:0] jump_address,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] jpend_q, jpend_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] jump_q, jump_d;
  logic             use_npc_q, use_npc_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] alu_b_s;
  logic [WIDTH-1:0] alu_res_s;
  logic [WIDTH-1:0] jump_s;
  logic             zero_s;
  logic             taken_s;
  logic             is_md_s;
  logic             accept_s;
  logic             in_ready_s;

  logic [WIDTH-1:0] mul_acc_s;
  logic [WIDTH:0]   rshift_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] rem_next_s;
  logic [WIDTH-1:0] quo_next_s;
  logic [WIDTH-1:0] iter_acc_s;
  logic [WIDTH-1:0] iter_opa_s;
  logic [WIDTH-1:0] iter_opb_s;
  logic [WIDTH-1:0] md_result_s;

  // ALU, zero flag, branch decision and jump target
  always_comb begin
    alu_b_s = control_use_b ? data_b : data_imm;
    case (control_alu_op)
      3'b000:  alu_res_s = data_a & alu_b_s;
      3'b001:  alu_res_s = data_a | alu_b_s;
      3'b010:  alu_res_s = data_a + alu_b_s;
      3'b011:  alu_res_s = ~(data_a | alu_b_s);
      3'b100:  alu_res_s = data_a & ~alu_b_s;
      3'b101:  alu_res_s = data_a | ~alu_b_s;
      3'b110:  alu_res_s = data_a - alu_b_s;
      3'b111:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(data_a) < $signed(alu_b_s))};
      default: alu_res_s = {WIDTH{1'b0}};
    endcase
    zero_s = (alu_res_s == {WIDTH{1'b0}});
    case (control_branch)
      2'b01:   taken_s = zero_s;
      2'b10:   taken_s = ~zero_s;
      default: taken_s = 1'b0;
    endcase
    jump_s  = npc + data_imm;
    is_md_s = MULDIV_EN && (control_muldiv != 2'b00);
  end

  // One shift-add or restoring-divide step; the divide path naturally yields
  // all-ones quotient and the dividend as remainder when the divisor is zero
  always_comb begin
    mul_acc_s  = acc_q + (opb_q[0] ? opa_q : {WIDTH{1'b0}});
    rshift_s   = {acc_q, opa_q[WIDTH-1]};
    diff_s     = rshift_s - {1'b0, opb_q};
    if (!diff_s[WIDTH]) begin
      rem_next_s = diff_s[WIDTH-1:0];
      quo_next_s = {opa_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_next_s = rshift_s[WIDTH-1:0];
      quo_next_s = {opa_q[WIDTH-2:0], 1'b0};
    end
    if (mode_q == 2'b01) begin
      iter_acc_s  = mul_acc_s;
      iter_opa_s  = {opa_q[WIDTH-2:0], 1'b0};
      iter_opb_s  = {1'b0, opb_q[WIDTH-1:1]};
      md_result_s = mul_acc_s;
    end else begin
      iter_acc_s  = rem_next_s;
      iter_opa_s  = quo_next_s;
      iter_opb_s  = opb_q;
      md_result_s = (mode_q == 2'b10) ? quo_next_s : rem_next_s;
    end
  end

  // Handshake, FSM next state and output register loading
  always_comb begin
    in_ready_s  = (state_q == IDLE) && (!out_valid_q || out_ready);
    accept_s    = in_valid && in_ready_s;
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    acc_d       = acc_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    jpend_d     = jpend_q;
    out_d       = out_q;
    jump_d      = jump_q;
    use_npc_d   = use_npc_q;
    if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    case (state_q)
      IDLE: begin
        if (accept_s && is_md_s) begin
          state_d = CALC;
          cnt_d   = CW'(WIDTH);
          mode_d  = control_muldiv;
          acc_d   = {WIDTH{1'b0}};
          opa_d   = data_a;
          opb_d   = data_b;
          jpend_d = jump_s;
        end else if (accept_s) begin
          out_d       = alu_res_s;
          use_npc_d   = ~taken_s;
          jump_d      = jump_s;
          out_valid_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        acc_d = iter_acc_s;
        opa_d = iter_opa_s;
        opb_d = iter_opb_s;
        if (cnt_q == {{(CW-1){1'b0}}, 1'b1}) begin
          state_d     = IDLE;
          out_d       = md_result_s;
          use_npc_d   = 1'b1;
          jump_d      = jpend_q;
          out_valid_d = 1'b1;
        end else begin
          state_d = CALC;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CALC);
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= {CW{1'b0}};
      mode_q      <= 2'b00;
      acc_q       <= {WIDTH{1'b0}};
      opa_q       <= {WIDTH{1'b0}};
      opb_q       <= {WIDTH{1'b0}};
      jpend_q     <= {WIDTH{1'b0}};
      out_q       <= {WIDTH{1'b0}};
      jump_q      <= {WIDTH{1'b0}};
      use_npc_q   <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      jpend_q     <= jpend_d;
      out_q       <= out_d;
      jump_q      <= jump_d;
      use_npc_q   <= use_npc_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready     = in_ready_s;
  assign out_valid    = out_valid_q;
  assign out          = out_q;
  assign use_npc      = use_npc_q;
  assign jump_address = jump_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_stage_exe_mc.sv
// Scoreboard bench for stage_exe_mc: expected results queued at issue, compared on consume.
module tb_stage_exe_mc;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] data_a, data_b, data_imm, npc;
  logic [2:0]   control_alu_op;
  logic         control_use_b;
  logic [1:0]   control_branch;
  logic [1:0]   control_muldiv;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         use_npc;
  logic [W-1:0] jump_address;
  logic         busy;

  typedef struct packed {
    logic [W-1:0] res;
    logic         use_npc;
    logic [W-1:0] jump;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests_run    = 0;
  int   tests_failed = 0;

  stage_exe_mc #(.WIDTH(W), .MULDIV_EN(1'b1)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .data_a(data_a), .data_b(data_b), .data_imm(data_imm), .npc(npc),
    .control_alu_op(control_alu_op), .control_use_b(control_use_b),
    .control_branch(control_branch), .control_muldiv(control_muldiv),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .use_npc(use_npc),
    .jump_address(jump_address), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] imm, input logic [W-1:0] pc,
                                 input logic [2:0] op, input logic useb,
                                 input logic [1:0] br, input logic [1:0] md);
    exp_t         e;
    logic [W-1:0] bb;
    logic [W-1:0] r;
    logic         tk;
    bb = useb ? b : imm;
    case (op)
      3'd0: r = a & bb;
      3'd1: r = a | bb;
      3'd2: r = a + bb;
      3'd3: r = ~(a | bb);
      3'd4: r = a & ~bb;
      3'd5: r = a | ~bb;
      3'd6: r = a - bb;
      default: r = ($signed(a) < $signed(bb)) ? 32'd1 : 32'd0;
    endcase
    tk = (br == 2'b01) ? (r == 32'd0) : (br == 2'b10) ? (r != 32'd0) : 1'b0;
    e.jump    = pc + imm;
    e.use_npc = ~tk;
    if (md == 2'b01) begin
      e.res = a * b; e.use_npc = 1'b1;
    end else if (md == 2'b10) begin
      e.res = (b == 32'd0) ? 32'hFFFF_FFFF : a / b; e.use_npc = 1'b1;
    end else if (md == 2'b11) begin
      e.res = (b == 32'd0) ? a : a % b; e.use_npc = 1'b1;
    end else begin
      e.res = r;
    end
    return e;
  endfunction

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] imm,
                       input logic [W-1:0] pc, input logic [2:0] op, input logic useb,
                       input logic [1:0] br, input logic [1:0] md);
    data_a = a; data_b = b; data_imm = imm; npc = pc;
    control_alu_op = op; control_use_b = useb; control_branch = br; control_muldiv = md;
    in_valid = 1'b1;
  endtask

  // Called away from clock edges; returns 1 time unit after the accept edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] imm,
                      input logic [W-1:0] pc, input logic [2:0] op, input logic useb,
                      input logic [1:0] br, input logic [1:0] md);
    int n = 0;
    drive(a, b, imm, pc, op, useb, br, md);
    while (!in_ready && n < 200) begin
      @(posedge clock); #1; n++;
    end
    if (n >= 200) check("accept_timeout", 64'd1, 64'd0);
    sb.push_back(model(a, b, imm, pc, op, useb, br, md));
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result();
    int n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clock); #1; n++;
    end
    if (n >= 200) check("result_timeout", 64'd1, 64'd0);
    @(posedge clock); #1;
  endtask

  // Consume-side scoreboard
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("out", 64'(out), 64'(mon_e.res));
        check("use_npc", 64'(use_npc), 64'(mon_e.use_npc));
        check("jump_address", 64'(jump_address), 64'(mon_e.jump));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   bad;
    exp_t ea, eb;
    reset = 1'b1; out_ready = 1'b1;
    drive(32'd0, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0, 2'b00, 2'b00);
    in_valid = 1'b0;
    #12;
    check("rst_out", 64'(out), 64'd0);
    check("rst_use_npc", 64'(use_npc), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clock); #1; reset = 1'b0;
    @(posedge clock); #1;

    send(32'd5, 32'd0, 32'd7, 32'h40, 3'd2, 1'b0, 2'b00, 2'b00);
    check("alu_out_valid", 64'(out_valid), 64'd1);
    check("alu_add_out", 64'(out), 64'd12);
    @(posedge clock); #1;

    send(32'd9, 32'd9, 32'h20, 32'h100, 3'd6, 1'b1, 2'b01, 2'b00);
    check("beq_use_npc", 64'(use_npc), 64'd0);
    check("beq_jump", 64'(jump_address), 64'h120);
    send(32'd9, 32'd9, 32'h20, 32'h100, 3'd6, 1'b1, 2'b10, 2'b00);
    check("bne_use_npc", 64'(use_npc), 64'd1);
    @(posedge clock); #1;

    send(32'hFFFF_FFFF, 32'd3, 32'd4, 32'h200, 3'd2, 1'b1, 2'b01, 2'b01);
    bad = 0;
    for (int k = 0; k < W; k++) begin
      if (!(busy && !in_ready && !out_valid)) bad++;
      @(posedge clock); #1;
    end
    check("mul_calc_window", 64'(bad), 64'd0);
    check("mul_done_valid", 64'(out_valid), 64'd1);
    check("mul_done_busy", 64'(busy), 64'd0);
    @(posedge clock); #1;

    send(32'd100, 32'd7, 32'd0, 32'h300, 3'd2, 1'b1, 2'b00, 2'b10); wait_result();
    send(32'd100, 32'd7, 32'd0, 32'h300, 3'd2, 1'b1, 2'b00, 2'b11); wait_result();
    send(32'd100, 32'd0, 32'd0, 32'h300, 3'd2, 1'b1, 2'b00, 2'b10); wait_result();
    send(32'd100, 32'd0, 32'd0, 32'h300, 3'd2, 1'b1, 2'b00, 2'b11); wait_result();
    send(32'hDEAD_BEEF, 32'h1234, 32'd0, 32'h0, 3'd2, 1'b1, 2'b00, 2'b01); wait_result();

    for (int i = 0; i < 8; i++) begin
      send($urandom, $urandom, $urandom, $urandom, 3'(i), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 2'b00);
    end
    wait_result();
    @(posedge clock); #1;

    out_ready = 1'b0;
    ea = model(32'd21, 32'd4, 32'd0, 32'h10, 3'd6, 1'b1, 2'b00, 2'b00);
    send(32'd21, 32'd4, 32'd0, 32'h10, 3'd6, 1'b1, 2'b00, 2'b00);
    eb = model(32'd3, 32'd0, 32'd8, 32'h20, 3'd2, 1'b0, 2'b00, 2'b00);
    drive(32'd3, 32'd0, 32'd8, 32'h20, 3'd2, 1'b0, 2'b00, 2'b00);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (in_ready || !out_valid || out !== ea.res) bad++;
      @(posedge clock); #1;
    end
    check("backpressure_hold", 64'(bad), 64'd0);
    sb.push_back(eb);
    out_ready = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    check("b2b_second_out", 64'(out), 64'(eb.res));
    wait_result();

    send(32'd100, 32'd7, 32'd0, 32'h0, 3'd2, 1'b1, 2'b00, 2'b10);
    repeat (22) @(posedge clock);
    #1; reset = 1'b1; #1;
    sb.delete(sb.size() - 1);
    check("midcalc_busy", 64'(busy), 64'd0);
    check("midcalc_out_valid", 64'(out_valid), 64'd0);
    check("midcalc_out", 64'(out), 64'd0);
    @(posedge clock); #1; reset = 1'b0;
    @(posedge clock); #1;
    check("midcalc_in_ready", 64'(in_ready), 64'd1);
    send(32'd40, 32'd2, 32'd0, 32'h50, 3'd2, 1'b1, 2'b00, 2'b00);
    wait_result();

    repeat (3) @(posedge clock);
    #1;
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
